gate2_truth_checker: RTL
========================

Name: gate2_truth_checker

Overview:
- Exhaustive stimulus/response stage for any 2-input cell in the switch-level library.
- Drives x/y into the gate under test and samples its z.
- Compares z against a parameterised truth table and reports the mismatch count, the first failing vector and pass/fail.
- Sits directly upstream of the gate (feeds x,y) and directly downstream of it (consumes z). Default table is NAND.

Parameters:
- TRUTH, 4'b0111, expected z indexed by {x,y}: bit0=00, bit1=01, bit2=10, bit3=11 (default = NAND).
- SETTLE, 2, idle cycles between applying a vector and sampling z; 0 is legal.
- LOOPS, 1, number of full 4-vector passes per run; must be ≥1.
- CW, 8, width of the mismatch counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  synchronous abort; return to IDLE.
- x  output  1  gate input A (MSB of vector).
- y  output  1  gate input B (LSB of vector).
- z  input  1  gate output; may be 0/1/X/Z.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of a completed run.
- pass  output  1  1 when the last completed run had err_cnt==0.
- err_cnt  output  CW  mismatch count of the current or last run; saturating.
- fail_valid  output  1  a mismatch has been recorded in this run.
- first_fail  output  2  {x,y} of the first mismatching vector.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, x=0, y=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0, internal vec/loop/settle counters=0. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - x=y=0, busy=0.
  - start=1 at an edge → APPLY with vec=0, loop=0, err_cnt=0, fail_valid=0, first_fail=0; pass unchanged.
- APPLY (1 cycle):
  - {x,y}=vec; busy=1.
  - → SETTLE with cnt=SETTLE, or → SAMPLE if SETTLE==0.
- SETTLE: hold {x,y}; decrement cnt; → SAMPLE when cnt reaches 1, giving exactly SETTLE cycles here.
- SAMPLE (1 cycle):
  - Compare z to TRUTH[vec] with 4-state case inequality; z of X or Z is a mismatch.
  - On mismatch: err_cnt increments, saturating at 2^CW−1. If fail_valid=0, set first_fail=vec and fail_valid=1.
  - If vec≠3: vec+1 → APPLY.
  - If vec==3 and loop<LOOPS−1: loop+1, vec=0 → APPLY.
  - Otherwise → DONE.
- DONE (1 cycle):
  - done=1; busy=1.
  - pass registered as (err_cnt==0), including the mismatch from the final SAMPLE.
  - → IDLE. err_cnt, first_fail and fail_valid hold until the next start.
- Latency: each vector takes SETTLE+2 cycles. done is high in the cycle after the 4·LOOPS·(SETTLE+2)-th edge following the start-sampling edge; with defaults that is edge 16.
- Outputs x, y, busy, done, pass are registered; no combinational path from z to any output.
- start while busy: ignored.
- start and abort together in IDLE: abort wins, remain IDLE.
- abort in any non-IDLE state: → IDLE next edge, no done pulse, pass forced 0, err_cnt/first_fail/fail_valid hold their partial values.
- abort in DONE: done still pulses (it is the current state's output); next state is IDLE.
- The z sample uses the value present at the SAMPLE-state edge only. z glitches during APPLY/SETTLE are ignored.

Test Plan:
- Ideal NAND behavioural model on z, defaults, start pulse:
  - x,y sequence 00,01,10,11, each held 4 cycles.
  - done pulses at edge 16 after start; pass=1, err_cnt=0, fail_valid=0.
- z stuck-at-1, defaults:
  - err_cnt=1, first_fail=2'b11, fail_valid=1, pass=0.
- z tied to 1'bz (floating output), defaults: err_cnt=4, first_fail=2'b00, pass=0.
- z stuck-at-0, LOOPS=100, CW=8:
  - 300 mismatches expected; err_cnt saturates at 255 and does not wrap.
  - first_fail=2'b00, done at edge 1600.
- Control pulses during a run:
  - start pulsed again at edge 5 of a run: ignored, done still at edge 16.
  - abort at edge 9: next cycle busy=0, no done, pass=0, x=y=0.
- rst_n low asynchronously mid-SETTLE (between clock edges):
  - All outputs 0 immediately, before the next edge.
  - After release, a fresh start runs to a normal done at edge 16.

Source files
------------

// File: rtl/gate2_truth_checker.sv
// gate2_truth_checker
//   Exhaustive stimulus/response checker for a 2-input gate. It walks
//   {x,y} through 00,01,10,11 (LOOPS times). For each vector it waits
//   SETTLE cycles, samples z and compares it with TRUTH[{x,y}] using
//   4-state case inequality, so an X or Z on z counts as a mismatch.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : run request, honoured only in IDLE
//   abort      : synchronous abort back to IDLE (beats start)
//   x, y       : registered gate inputs (x = vector MSB)
//   z          : gate output under test (0/1/X/Z)
//   busy       : run in progress (APPLY..DONE)
//   done       : one-cycle pulse at end of a completed run
//   pass       : last completed run had no mismatches
//   err_cnt    : saturating mismatch count of current/last run
//   fail_valid : a mismatch has been recorded in this run
//   first_fail : {x,y} of the first mismatching vector
module gate2_truth_checker #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 2,
  parameter int         LOOPS  = 1,
  parameter int         CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          x,
  output logic          y,
  input  logic          z,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic          fail_valid,
  output logic [1:0]    first_fail
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      vec_q, vec_d;
  logic [LW-1:0]   loop_q, loop_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [1:0]      ff_q, ff_d;
  logic            x_q, x_d;
  logic            y_q, y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            mismatch;
  logic            abort_run;

  // Only the z value present at the SAMPLE edge is ever used.
  assign mismatch  = (z !== TRUTH[vec_q]);
  assign abort_run = abort && (state_q != S_IDLE);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      loop_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_APPLY;
          vec_d   = '0;
          loop_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
        end
      end
      S_APPLY: begin
        if (SETTLE == 0) begin
          state_d = S_SAMPLE;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SW'(SETTLE);
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= SW'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = S_APPLY;
        end else if (loop_q < LW'(LOOPS - 1)) begin
          loop_d  = loop_q + 1'b1;
          vec_d   = '0;
          state_d = S_APPLY;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort discards the in-flight sample; partial results are kept.
    if (abort_run) begin
      state_d = S_IDLE;
      vec_d   = '0;
      loop_d  = '0;
      cnt_d   = '0;
      err_d   = err_q;
      fv_d    = fv_q;
      ff_d    = ff_q;
    end
  end

  // Outputs are computed from the next state so they are registered
  // yet aligned with the state they belong to.
  always_comb begin
    x_d    = 1'b0;
    y_d    = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    pass_d = pass_q;

    if (state_d == S_APPLY || state_d == S_SETTLE || state_d == S_SAMPLE) begin
      x_d = vec_d[1];
      y_d = vec_d[0];
    end

    // err_d already includes the final sample's result here.
    if (state_q == S_SAMPLE && state_d == S_DONE) pass_d = (err_d == '0);

    if (abort_run) pass_d = 1'b0;
  end

  assign x          = x_q;
  assign y          = y_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule
